// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port round-robin/fixed-priority cache-line arbiter onto a single LLC port
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int LINE_WIDTH = 128,
  parameter int RR_MODE    = 1,
  parameter int TIMEOUT    = 1024,
  localparam int IDW       = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_ready,
  output logic                             port_err,
  output logic [LINE_WIDTH-1:0]            port_rdata,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy,
  output logic                             is_mem_req,
  output logic                             is_memory_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr_out,
  output logic [LINE_WIDTH-1:0]            mem_data_out,
  input  logic [LINE_WIDTH-1:0]            data_from_mem,
  input  logic                             is_mem_ready,
  output logic                             is_mem_req_reset
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]    cooldown_q, cooldown_d;
  logic [NUM_PORTS-1:0]    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d;
  logic                    req_reset_q, req_reset_d;
  logic [WDW-1:0]          wd_q, wd_d;

  logic [NUM_PORTS-1:0]    eligible;
  logic                    win_valid;
  logic [IDW-1:0]          win_idx;
  logic [IDW-1:0]          cand;

  // Scan candidates from the far end down so the nearest eligible index is assigned last.
  always_comb begin
    eligible  = port_req & ~cooldown_q;
    win_valid = |eligible;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (RR_MODE != 0) cand = IDW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      else              cand = IDW'(k);
      if (eligible[cand]) win_idx = cand;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cooldown_d  = cooldown_q;
    ready_d     = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_reset_d = 1'b0;
    wd_d        = wd_q;
    unique case (state_q)
      S_IDLE: begin
        cooldown_d = '0;
        if (win_valid) begin
          grant_d = win_idx;
          addr_d  = port_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = port_wdata[win_idx*LINE_WIDTH +: LINE_WIDTH];
          we_d    = port_we[win_idx];
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        wd_d = wd_q + WDW'(1);
        // A memory answer on the same edge as the watchdog expiry is a success.
        if (is_mem_ready || (TIMEOUT != 0 && wd_q == WD_LAST)) begin
          rdata_d     = is_mem_ready ? data_from_mem : '0;
          err_d       = ~is_mem_ready;
          ready_d     = NUM_PORTS'(1) << grant_q;
          req_reset_d = 1'b1;
          busy_d      = 1'b0;
          we_d        = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (RR_MODE != 0) rr_ptr_d = IDW'((int'(grant_q) + 1) % NUM_PORTS);
        cooldown_d = NUM_PORTS'(1) << grant_q;
        wd_d       = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cooldown_q  <= '0;
      ready_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      req_reset_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cooldown_q  <= cooldown_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_reset_q <= req_reset_d;
      wd_q        <= wd_d;
    end
  end

  assign port_ready       = ready_q;
  assign port_err         = err_q;
  assign port_rdata       = rdata_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;
  assign is_mem_req       = busy_q;
  assign is_memory_we     = we_q;
  assign mem_addr_out     = addr_q;
  assign mem_data_out     = data_q;
  assign is_mem_req_reset = req_reset_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - directed vector bench for mem_arbiter_rr (round-robin and fixed-priority instances)
module tb_mem_arbiter_rr;

  localparam int NP = 4;
  localparam int AW = 20;
  localparam int LW = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   port_req;
  logic [NP-1:0]   port_we;
  logic [NP*AW-1:0] port_addr;
  logic [NP*LW-1:0] port_wdata;
  logic [LW-1:0]   data_from_mem;
  logic            is_mem_ready;

  logic [NP-1:0]   port_ready, f_port_ready;
  logic            port_err, f_port_err;
  logic [LW-1:0]   port_rdata, f_port_rdata;
  logic [1:0]      grant_id, f_grant_id;
  logic            busy, f_busy;
  logic            is_mem_req, f_is_mem_req;
  logic            is_memory_we, f_is_memory_we;
  logic [AW-1:0]   mem_addr_out, f_mem_addr_out;
  logic [LW-1:0]   mem_data_out, f_mem_data_out;
  logic            is_mem_req_reset, f_is_mem_req_reset;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ready(port_ready), .port_err(port_err), .port_rdata(port_rdata),
    .grant_id(grant_id), .busy(busy), .is_mem_req(is_mem_req), .is_memory_we(is_memory_we),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .data_from_mem(data_from_mem),
    .is_mem_ready(is_mem_ready), .is_mem_req_reset(is_mem_req_reset)
  );

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(0), .TIMEOUT(0)) dut_fixed (
    .clk(clk), .reset(reset), .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ready(f_port_ready), .port_err(f_port_err), .port_rdata(f_port_rdata),
    .grant_id(f_grant_id), .busy(f_busy), .is_mem_req(f_is_mem_req), .is_memory_we(f_is_memory_we),
    .mem_addr_out(f_mem_addr_out), .mem_data_out(f_mem_data_out), .data_from_mem(data_from_mem),
    .is_mem_ready(is_mem_ready), .is_mem_req_reset(f_is_mem_req_reset)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [19:0] addr;
    logic [127:0] wdata;
    int          lat;        // edge at which is_mem_ready is first seen; 0 = never
    logic [127:0] mem_data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_grant;
    logic [127:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " port_ready"}, port_ready, 0);
    check({tag, " port_err"}, port_err, 0);
    check({tag, " port_rdata"}, port_rdata, 0);
    check({tag, " grant_id"}, grant_id, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " is_mem_req"}, is_mem_req, 0);
    check({tag, " is_memory_we"}, is_memory_we, 0);
    check({tag, " mem_addr_out"}, mem_addr_out, 0);
    check({tag, " mem_data_out"}, mem_data_out, 0);
    check({tag, " is_mem_req_reset"}, is_mem_req_reset, 0);
  endtask

  task automatic wait_busy(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = busy;
    end
    if (!ok) check({name, " busy timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit stable;
    bit ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    port_we[v.port] = v.we;
    port_addr[v.port*AW +: AW] = v.addr;
    port_wdata[v.port*LW +: LW] = v.wdata;
    data_from_mem = v.mem_data;
    is_mem_ready = 1'b0;
    port_req[v.port] = 1'b1;
    wait_busy(tag, ok);
    if (!ok) begin
      port_req = '0;
      return;
    end
    check({tag, " grant_id"}, grant_id, v.exp_grant);
    check({tag, " mem_addr_out"}, mem_addr_out, v.addr);
    check({tag, " is_memory_we"}, is_memory_we, v.we);
    cyc = 0;
    stable = 1'b1;
    while (port_ready == '0 && cyc < 40) begin
      if (v.lat != 0 && cyc + 1 == v.lat) is_mem_ready = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (port_ready == '0)
        stable &= (is_mem_req && mem_addr_out == v.addr && is_memory_we == v.we &&
                   (!v.we || mem_data_out == v.wdata));
    end
    is_mem_ready = 1'b0;
    port_req[v.port] = 1'b0;
    check({tag, " busy window stable"}, stable, 1);
    check({tag, " req-to-ready cycles"}, cyc, v.exp_cyc);
    check({tag, " port_ready"}, port_ready, v.exp_ready);
    check({tag, " port_rdata"}, port_rdata, v.exp_rdata);
    check({tag, " port_err"}, port_err, v.exp_err);
    check({tag, " req_reset/busy/mem_req in resp"}, {is_mem_req_reset, busy, is_mem_req, is_memory_we}, 4'b1000);
    @(negedge clk);
    check({tag, " pulses single cycle"}, {port_ready, port_err, is_mem_req_reset}, 0);
    @(negedge clk);
  endtask

  initial begin
    int gm[8];
    int gf[8];
    int exp_rr[8];
    int exp_fx[8];
    int nm, nf, pulses;
    bit pb, pfb, ok;

    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_fx = '{0, 1, 0, 1, 0, 1, 0, 1};

    vecs[0] = '{2, 1'b0, 20'h0ABCD, 128'h0, 3,
                128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 4'b0100, 2'd2,
                128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1'b0, 3};
    vecs[1] = '{1, 1'b1, 20'h00040, 128'h1234_0000_AAAA_BBBB_CCCC_DDDD_EEEE_5678, 2,
                128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 4'b0010, 2'd1,
                128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 1'b0, 2};
    vecs[2] = '{3, 1'b0, 20'h7FFFF, 128'h0, 0,
                {4{32'hFFFF_FFFF}}, 4'b1000, 2'd3, 128'h0, 1'b1, 16};
    vecs[3] = '{0, 1'b0, 20'hFFFFF, 128'h0, 1,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 4'b0001, 2'd0,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, 1};
    vecs[4] = '{3, 1'b0, 20'h12345, 128'h0, 16,
                128'h0000_0000_0000_0000_0000_0000_00C0_FFEE, 4'b1000, 2'd3,
                128'h0000_0000_0000_0000_0000_0000_00C0_FFEE, 1'b0, 16};

    reset = 1'b0;
    port_req = '0;
    port_we = '0;
    port_addr = {20'h33333, 20'h22222, 20'h11111, 20'h00001};
    port_wdata = {{4{32'h3333_3333}}, {4{32'h2222_2222}}, {4{32'h1111_1111}}, {4{32'h0000_0001}}};
    data_from_mem = '0;
    is_mem_ready = 1'b0;

    do_reset();
    @(negedge clk);
    check_zero_outputs("reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Fairness: all ports hold requests, LLC answers immediately.
    do_reset();
    is_mem_ready = 1'b1;
    port_req = 4'hF;
    nm = 0; nf = 0; pb = 1'b0; pfb = 1'b0;
    for (int i = 0; i < 60 && (nm < 8 || nf < 8); i++) begin
      @(negedge clk);
      if (busy && !pb && nm < 8) begin gm[nm] = int'(grant_id); nm++; end
      if (f_busy && !pfb && nf < 8) begin gf[nf] = int'(f_grant_id); nf++; end
      pb = busy;
      pfb = f_busy;
    end
    port_req = '0;
    repeat (5) @(negedge clk);
    is_mem_ready = 1'b0;
    check("rr grant count", nm, 8);
    check("fixed grant count", nf, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < nm) check($sformatf("rr grant[%0d]", i), gm[i], exp_rr[i]);
      if (i < nf) check($sformatf("fixed grant[%0d]", i), gf[i], exp_fx[i]);
    end

    // Cooldown: port 0 keeps requesting one cycle past its ready while port 3 waits.
    do_reset();
    is_mem_ready = 1'b1;
    port_req = 4'b1001;
    wait_busy("cooldown first", ok);
    check("cooldown first grant rr", grant_id, 0);
    check("cooldown first grant fixed", f_grant_id, 0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = port_ready[0];
    end
    check("cooldown port0 ready", ok, 1);
    @(negedge clk);
    check("cooldown idle cycle", busy, 0);
    @(negedge clk);
    port_req = '0;
    check("cooldown second busy", busy, 1);
    check("cooldown second grant rr", grant_id, 3);
    check("cooldown second grant fixed", f_grant_id, 3);
    repeat (4) @(negedge clk);
    is_mem_ready = 1'b0;

    // Reset mid-BUSY after moving rr_ptr to 2.
    run_vec(vecs[1], 5);
    port_req[2] = 1'b1;
    wait_busy("midreset", ok);
    check("midreset grant", grant_id, 2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    port_req = '0;
    @(negedge clk);
    reset = 1'b1;
    check_zero_outputs("midreset");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port_ready != '0 || busy) pulses++;
    end
    check("midreset no ready/busy after abort", pulses, 0);
    port_req = 4'b0110;
    is_mem_ready = 1'b1;
    wait_busy("midreset rr_ptr", ok);
    check("midreset rr_ptr cleared", grant_id, 1);
    port_req = '0;
    repeat (4) @(negedge clk);
    is_mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
